// File: rtl/util_delay_pipe.sv
// Fixed-latency data/valid delay line with stall and flush.
// DELAY = 0 gives a combinational pass-through.
module util_delay_pipe #(
  parameter int unsigned        WIDTH = 32,
  parameter int unsigned        DELAY = 2,
  parameter logic [WIDTH-1:0]   RESET = WIDTH'(0),
  localparam int unsigned       CW    = (DELAY == 0) ? 1 : $clog2(DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    count
);

  if (DELAY == 0) begin : g_bypass
    // Control inputs have no effect without storage; fold them away explicitly.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, stall, flush};

    assign out       = in;
    assign out_valid = in_valid;
    assign count     = '0;
  end else begin : g_pipe
    // Index 0 is stage 1 (entry), index DELAY-1 is the output stage.
    logic [DELAY-1:0][WIDTH-1:0] d;
    logic [DELAY-1:0]            v;
    logic [CW-1:0]               cnt;

    // Priority: reset > flush > stall > shift.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        for (int k = 0; k < DELAY; k++) begin
          d[k] <= RESET;
          v[k] <= 1'b0;
        end
      end else if (!stall) begin
        d[0] <= in;
        v[0] <= in_valid;
        for (int k = 1; k < DELAY; k++) begin
          d[k] <= d[k-1];
          v[k] <= v[k-1];
        end
      end
    end

    // Occupancy: popcount of the valid bits; CW always fits DELAY.
    always_comb begin
      cnt = '0;
      for (int k = 0; k < DELAY; k++) begin
        cnt = cnt + CW'(v[k]);
      end
    end

    assign out       = d[DELAY-1];
    assign out_valid = v[DELAY-1];
    assign count     = cnt;
  end

endmodule

// File: tb/tb_util_delay_pipe.sv
// Directed self-checking bench for util_delay_pipe (DELAY = 3 and DELAY = 0 instances).
module tb_util_delay_pipe;

  logic       clk = 1'b0;
  logic       reset, stall, flush, in_valid;
  logic [7:0] in;
  logic       out_valid;
  logic [7:0] out;
  logic [1:0] count;

  logic       reset0, stall0, flush0, in_valid0;
  logic [7:0] in0;
  logic       out_valid0;
  logic [7:0] out0;
  logic [0:0] count0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  util_delay_pipe #(.WIDTH(8), .DELAY(3), .RESET(8'hA5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out(out), .count(count)
  );

  util_delay_pipe #(.WIDTH(8), .DELAY(0), .RESET(8'hA5)) dut0 (
    .clk(clk), .reset(reset0), .stall(stall0), .flush(flush0),
    .in_valid(in_valid0), .in(in0),
    .out_valid(out_valid0), .out(out0), .count(count0)
  );

  // Advance one rising edge and settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in = 8'hFF; stall = 1'b0; flush = 1'b0;
    step();
    step();
    n_checks++;
    if (out !== 8'hA5) begin n_fail++; $display("FAIL reset_out got=%h exp=a5", out); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    idle_inputs();
  endtask

  task automatic test_streaming();
    logic [7:0] ins    [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    logic       ivs    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_ov [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d  [7] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    logic [1:0] exp_c  [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 7; i++) begin
      in = ins[i]; in_valid = ivs[i];
      step();
      n_checks++;
      if (out_valid !== exp_ov[i]) begin
        n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, exp_ov[i]);
      end
      n_checks++;
      if (count !== exp_c[i]) begin
        n_fail++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]);
      end
      if (exp_ov[i]) begin
        n_checks++;
        if (out !== exp_d[i]) begin
          n_fail++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out, exp_d[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [7:0] ins    [11] = '{8'h10, 8'h11, 8'h12, 8'hEE, 8'hEE, 8'h13, 8'h14, 8'h15,
                                8'h00, 8'h00, 8'h00};
    logic       ivs    [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic       stl    [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    logic       exp_ov [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] exp_d  [11] = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h14, 8'h15, 8'h00};
    logic [1:0] exp_c  [11] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                                2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 11; i++) begin
      in = ins[i]; in_valid = ivs[i]; stall = stl[i];
      step();
      n_checks++;
      if (out_valid !== exp_ov[i]) begin
        n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=%b", i, out_valid, exp_ov[i]);
      end
      n_checks++;
      if (count !== exp_c[i]) begin
        n_fail++; $display("FAIL stall_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]);
      end
      if (exp_ov[i]) begin
        n_checks++;
        if (out !== exp_d[i]) begin
          n_fail++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, out, exp_d[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush_stall();
    for (int i = 0; i < 3; i++) begin
      in = 8'h21 + 8'(i); in_valid = 1'b1;
      step();
    end
    n_checks++;
    if (count !== 2'd3 || out_valid !== 1'b1 || out !== 8'h21) begin
      n_fail++;
      $display("FAIL flush_prefill got cnt=%0d ov=%b out=%h exp cnt=3 ov=1 out=21",
               count, out_valid, out);
    end
    flush = 1'b1; stall = 1'b1; in = 8'h77; in_valid = 1'b1;
    step();
    n_checks++;
    if (out !== 8'hA5) begin n_fail++; $display("FAIL flush_out got=%h exp=a5", out); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
    idle_inputs();
    step();
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL flush_dropped_input got=%0d exp=0", count); end
  endtask

  task automatic test_reset_priority();
    in = 8'h31; in_valid = 1'b1;
    step();
    in = 8'h32;
    step();
    reset = 1'b1; flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in = 8'hFF;
    step();
    n_checks++;
    if (out !== 8'hA5) begin n_fail++; $display("FAIL rstprio_out got=%h exp=a5", out); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstprio_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL rstprio_count got=%0d exp=0", count); end
    idle_inputs();
    step();
    n_checks++;
    if (count !== 2'd0 || out !== 8'hA5) begin
      n_fail++; $display("FAIL rstprio_no_capture got cnt=%0d out=%h exp cnt=0 out=a5", count, out);
    end
  endtask

  task automatic test_delay0();
    reset0 = 1'b0; flush0 = 1'b0; stall0 = 1'b1; in0 = 8'h3C; in_valid0 = 1'b1;
    #1;
    n_checks++;
    if (out0 !== 8'h3C) begin n_fail++; $display("FAIL d0_out got=%h exp=3c", out0); end
    n_checks++;
    if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL d0_out_valid got=%b exp=1", out_valid0); end
    n_checks++;
    if (count0 !== 1'b0) begin n_fail++; $display("FAIL d0_count got=%0d exp=0", count0); end
    reset0 = 1'b1; flush0 = 1'b1; in0 = 8'hC3; in_valid0 = 1'b0;
    step();
    n_checks++;
    if (out0 !== 8'hC3 || out_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL d0_passthru got out=%h ov=%b exp out=c3 ov=0", out0, out_valid0);
    end
  endtask

  initial begin
    idle_inputs();
    reset0 = 1'b0; stall0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0; in0 = 8'h00;
    #2;
    test_reset();
    test_streaming();
    test_stall();
    test_flush_stall();
    test_reset_priority();
    test_delay0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/util_delay_pipe.md
UTIL_DELAY_PIPE -- requirements
Module: Util_Delay_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data lane width in bits, 1..1024.
REQ-002 SHALL have parameter DELAY, default 2: pipeline depth in cycles, 0..64.
REQ-003 SHALL have parameter RESET, default WIDTH'(0): WIDTH-bit value loaded into every data stage on reset or flush.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1: hold all stages.
REQ-007 SHALL have port flush, input, 1: invalidate all stages.
REQ-008 SHALL have port in_valid, input, 1: qualifier for in.
REQ-009 SHALL have port in, input, WIDTH: data entering stage 1.
REQ-010 SHALL have port out_valid, output, 1: valid bit of the last stage.
REQ-011 SHALL have port out, output, WIDTH: data of the last stage.
REQ-012 SHALL have port count, output, CW = max(1, clog2(DELAY+1)): number of valid stages.

Function
REQ-013 SHALL hold DELAY stages; each stage k in 1..DELAY has a WIDTH-bit data register d[k] and a valid register v[k].
REQ-014 SHALL use per-edge priority: reset > flush > stall > shift.
REQ-015 SHALL, on shift, load d[1] <= in and v[1] <= in_valid, and for k > 1 load d[k] <= d[k-1] and v[k] <= v[k-1].
REQ-016 SHALL capture d[1] on shift regardless of in_valid; data of an invalid slot is don't-care but deterministic.
REQ-017 SHALL, on stall (no reset, no flush), hold every d[k] and v[k]; in and in_valid presented that cycle are dropped.
REQ-018 SHALL, on flush (no reset), load every d[k] <= RESET and v[k] <= 0; flush overrides stall; in presented that cycle is dropped.
REQ-019 SHALL drive out = d[DELAY] and out_valid = v[DELAY] directly from registers, with no combinational path from inputs when DELAY >= 1.
REQ-020 SHALL give latency exactly DELAY non-stalled rising edges from in to out.
REQ-021 SHALL drive count combinationally as the popcount of v[1..DELAY], range 0..DELAY, never wrapping.
REQ-022 SHALL, for DELAY = 0, make out = in and out_valid = in_valid combinationally, drive count = 0, and ignore stall, flush and reset.
REQ-023 SHALL assert no handshake back-pressure; the upstream stage owns stall generation.

Reset
REQ-024 SHALL, while reset is high at a rising edge, load every d[k] <= RESET and v[k] <= 0, giving out = RESET, out_valid = 0 and count = 0 from the following cycle.
REQ-025 SHALL let reset override concurrent flush, stall and in_valid.
REQ-026 SHALL leave outputs undefined before the first reset edge; the bench applies reset first.

Verification
All scenarios use WIDTH = 8, DELAY = 3, RESET = 8'hA5 unless stated.
REQ-027 SHALL cover reset: reset high for 2 edges with in_valid = 1 and in = 8'hFF -> out = 8'hA5, out_valid = 0, count = 0.
REQ-028 SHALL cover streaming:
- stimulus: in_valid = 1, in = 01, 02, 03, 04 on consecutive cycles, then in_valid = 0;
- response: out = 01 with out_valid = 1 after the 3rd edge, then 02, 03, 04;
- response: count ramps 1, 2, 3, 3 then drains 2, 1, 0.
REQ-029 SHALL cover stall:
- stimulus: while streaming, stall high for 2 cycles with in = 0xEE;
- response: out, out_valid and count frozen for 2 cycles;
- response: 0xEE never appears at out, and the sequence resumes without gaps or duplicates.
REQ-030 SHALL cover flush with stall: pipeline holding 3 valid entries, flush = 1 and stall = 1 together -> next cycle out = 8'hA5, out_valid = 0, count = 0.
REQ-031 SHALL cover reset priority: reset = 1 with flush = 1, stall = 1 and in_valid = 1 -> identical result to REQ-027, and the input is not captured.
REQ-032 SHALL cover the DELAY = 0 instance: in = 8'h3C with in_valid = 1 -> out = 8'h3C, out_valid = 1 in the same cycle, count = 0, even with stall = 1.
